sync_frame_tx: RTL and testbench
================================

# sync_frame_tx

Serial frame transmitter for the Moore "1001" sequence detector on the receive side. It accepts a parallel payload word through a valid/ready handshake, then emits on a single-bit line:
- the sync preamble 1001,
- the payload MSB-first, with zero-bit stuffing so the preamble pattern can never appear inside the payload,
- an idle gap.

The receiving detector sees exactly one 1001 per frame. That match marks the frame start.

## Interface
- DATA_W, 8, payload width in bits (≥ 2)
- PREAMBLE, 4'b1001, sync pattern, sent MSB-first; fixed width 4
- GAP_CYCLES, 1, idle cycles after each frame (0 allowed)
- STUFF_EN, 1, 1 = stuffing enabled, 0 = payload sent raw
- clk  input  1  clock, all logic on rising edge
- reset  input  1  reset, asynchronous, active-high
- load_valid  input  1  payload offered
- load_data  input  DATA_W  payload word, sampled on handshake
- load_ready  output  1  block can accept; equals (state==IDLE) && !reset
- dout  output  1  serial line, registered
- dout_valid  output  1  dout carries a frame bit, registered
- busy  output  1  state != IDLE
- frame_done  output  1  one-cycle pulse, coincident with the last payload bit

## Operation
- States: IDLE, PRE, DATA, GAP (enum `tx_state_t`).
- IDLE:
  - dout=0, dout_valid=0.
  - A handshake (load_valid && load_ready) latches load_data into the shift register, clears the 3-bit history, clears the bit counter and moves to PRE.
- PRE:
  - Outputs PREAMBLE[3]..PREAMBLE[0], one bit per cycle, with dout_valid=1.
  - Every output bit shifts into the history (newest bit in LSB).
  - After the 4th bit, moves to DATA.
- DATA, each cycle:
  - If STUFF_EN and history==3'b100: output a stuff bit 0. The payload is not shifted and the counter is not advanced.
  - Otherwise: output the shift-register MSB, shift left and advance the counter.
  - History updates with every output bit, stuff bits included.
  - When the DATA_W-th payload bit is output, frame_done=1 in that cycle.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- Stuffing rule:
  - The history spans the preamble/payload boundary.
  - No stuffing check is made after the last payload bit.
  - Stuff count per frame is data-dependent: 0 … ceil(DATA_W/3).
- GAP: dout=0, dout_valid=0 for GAP_CYCLES cycles, then IDLE.
- load_valid outside IDLE is ignored; nothing is queued.
- Reset values: dout=0, dout_valid=0, busy=0, frame_done=0, load_ready=0 while reset is high, state=IDLE, history=0.

## Timing
- A handshake on cycle N puts the first preamble bit on dout/dout_valid at cycle N+1.
- Frame length in valid cycles: 4 + DATA_W + stuffs, with no bubbles inside a frame.
- load_ready rises on the cycle after the last gap cycle. With GAP_CYCLES=0, it rises on the cycle after the last payload bit.
- Minimum handshake-to-handshake period: 1 + 4 + DATA_W + stuffs + GAP_CYCLES.
- Reset mid-frame: outputs clear immediately (asynchronously). frame_done does not fire for the aborted frame. The line stays idle until the next handshake after reset is released.
- load_valid and reset asserted together: reset wins and nothing is latched.

## Structure
- Shared package `sync_frame_pkg`:
  - `tx_state_t`
  - `SYNC_PREAMBLE` = 4'b1001
  - `SYNC_PRE_W` = 4
- The detector side shares the same package.
- One sub-module is natural: `bit_stuffer`. It holds the 3-bit history register and produces the stuff decision; inputs are clear, shift-enable and the output bit.
- The top module holds the FSM, the payload shift register, the counters and the output registers.

## Test plan
Unless stated otherwise, runs use DATA_W=8, GAP_CYCLES=1, STUFF_EN=1.
- Load 8'hFF: 12 valid bits 1001_11111111; frame_done on the 12th; 1 gap cycle; load_ready back 14 cycles after the handshake.
- Load 8'hA5: 13 valid bits 1001_10100_0_101; exactly one stuff bit, after payload bit 5.
- Load 8'h99: 14 valid bits 1001_100_0_1100_0_1; a golden 1001 overlapping detector model fires exactly once, on preamble bit 4.
- Load 8'h00 with STUFF_EN=0: 12 bits 1001_00000000. With STUFF_EN=1: 13 bits 1001_00_0_000000.
- Reset pulse in the 3rd payload cycle: dout/dout_valid drop to 0 at once; no frame_done; a new load of 8'hFF after release yields the clean frame from the first scenario.
- GAP_CYCLES=0 with load_valid held high over 3 words (8'hFF, 8'h00, 8'hA5): frames back-to-back with exactly 1 idle cycle between them (the IDLE handshake cycle); load_valid ignored while busy; 3 frame_done pulses.

Source files
------------

// File: rtl/sync_frame_pkg.sv
// Shared definitions for the 1001-sync serial link (transmitter and detector).
package sync_frame_pkg;

    localparam int              SYNC_PRE_W    = 4;
    localparam logic [SYNC_PRE_W-1:0] SYNC_PREAMBLE = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        GAP
    } tx_state_t;

    // After "100" a 1 would complete the sync pattern, so a 0 must be forced.
    function automatic logic stuff_needed(input logic [2:0] hist);
        return hist == 3'b100;
    endfunction

endpackage

// File: rtl/sync_frame_tx_if.sv
// Load handshake and serial line of the sync frame transmitter.
interface sync_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              dout;
    logic              dout_valid;
    logic              busy;
    logic              frame_done;

    modport master (
        output load_valid, load_data,
        input  load_ready, dout, dout_valid, busy, frame_done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, dout, dout_valid, busy, frame_done
    );
endinterface

// File: rtl/sync_frame_tx_bit_stuffer.sv
// History of the last three line bits and the resulting zero-stuff decision.
module bit_stuffer
    import sync_frame_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic stuff
);

    logic [2:0] hist;

    // A clear together with a shift starts the history with the new bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hist <= 3'b000;
        else if (shift_en)
            hist <= {(clear ? 2'b00 : hist[1:0]), bit_in};
        else if (clear)
            hist <= 3'b000;
    end

    assign stuff = stuff_needed(hist);

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 1001 preamble, zero-stuffed MSB-first payload, idle gap.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                    DATA_W     = 8,
    parameter logic [SYNC_PRE_W-1:0] PREAMBLE   = SYNC_PREAMBLE,
    parameter int                    GAP_CYCLES = 1,
    parameter bit                    STUFF_EN   = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    sync_frame_tx_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bcnt;
    logic [1:0]        pcnt;
    logic [GAP_W-1:0]  gcnt;
    logic              dout_q, dv_q, fd_q;

    logic hs, stuff_raw, stuff_bit, tx_bit, tx_en;

    assign hs        = bus.load_valid && bus.load_ready;
    assign stuff_bit = STUFF_EN && stuff_raw;

    // Bit going onto the line next cycle; the FSM state names what is being generated.
    always_comb begin
        tx_bit = 1'b0;
        tx_en  = 1'b0;
        case (state)
            IDLE: if (hs) begin
                tx_en  = 1'b1;
                tx_bit = PREAMBLE[SYNC_PRE_W-1];
            end
            PRE: begin
                tx_en  = 1'b1;
                tx_bit = PREAMBLE[~pcnt];
            end
            DATA: begin
                tx_en  = 1'b1;
                tx_bit = stuff_bit ? 1'b0 : shreg[DATA_W-1];
            end
            default: ;
        endcase
    end

    bit_stuffer u_stuffer (
        .clk      (clk),
        .reset    (reset),
        .clear    (hs),
        .shift_en (tx_en),
        .bit_in   (tx_bit),
        .stuff    (stuff_raw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bcnt   <= '0;
            pcnt   <= '0;
            gcnt   <= '0;
            dout_q <= 1'b0;
            dv_q   <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            dout_q <= tx_bit;
            dv_q   <= tx_en;
            fd_q   <= 1'b0;
            case (state)
                IDLE: if (hs) begin
                    shreg <= bus.load_data;
                    bcnt  <= '0;
                    pcnt  <= 2'd1;
                    state <= PRE;
                end
                PRE: begin
                    pcnt <= pcnt + 2'd1;
                    if (pcnt == 2'd3)
                        state <= DATA;
                end
                DATA: if (!stuff_bit) begin
                    shreg <= shreg << 1;
                    bcnt  <= bcnt + CNT_W'(1);
                    if (bcnt == LAST_BIT) begin
                        fd_q  <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    // Entered while the last payload bit is on the line, so it
                    // is held for GAP_CYCLES further cycles before IDLE.
                    if (gcnt == GAP_W'(GAP_CYCLES))
                        state <= IDLE;
                    else
                        gcnt <= gcnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = (state == IDLE) && !reset;
    assign bus.busy       = (state != IDLE);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: three configurations, hand-computed frames.
module tb_sync_frame_tx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sync_frame_tx_if #(.DATA_W(8)) if0 ();
    sync_frame_tx_if #(.DATA_W(8)) if1 ();
    sync_frame_tx_if #(.DATA_W(8)) if2 ();

    sync_frame_tx #(.DATA_W(8), .PREAMBLE(4'b1001), .GAP_CYCLES(1), .STUFF_EN(1'b1))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    sync_frame_tx #(.DATA_W(8), .PREAMBLE(4'b1001), .GAP_CYCLES(1), .STUFF_EN(1'b0))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    sync_frame_tx #(.DATA_W(8), .PREAMBLE(4'b1001), .GAP_CYCLES(0), .STUFF_EN(1'b1))
        u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    int checks = 0;
    int errors = 0;

    int          cur;
    logic [63:0] bits;
    int          len, fd, fdpos, first_v, last_v, det, detpos, ticks;
    logic [3:0]  dsh;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bits = '0; len = 0; fd = 0; fdpos = 0; first_v = -1; last_v = -1;
        det = 0; detpos = 0; dsh = 4'b0000; ticks = 0;
    endtask

    task automatic set_load(input int k, input logic v, input logic [7:0] d);
        case (k)
            0: begin if0.load_valid = v; if0.load_data = d; end
            1: begin if1.load_valid = v; if1.load_data = d; end
            default: begin if2.load_valid = v; if2.load_data = d; end
        endcase
    endtask

    function automatic logic ready_of(input int k);
        case (k)
            0: return if0.load_ready;
            1: return if1.load_ready;
            default: return if2.load_ready;
        endcase
    endfunction

    // One cycle: sample the selected instance mid-cycle and run the golden 1001 detector.
    task automatic tick();
        logic d, v, f;
        @(negedge clk);
        ticks++;
        case (cur)
            0: begin d = if0.dout; v = if0.dout_valid; f = if0.frame_done; end
            1: begin d = if1.dout; v = if1.dout_valid; f = if1.frame_done; end
            default: begin d = if2.dout; v = if2.dout_valid; f = if2.frame_done; end
        endcase
        dsh = {dsh[2:0], d};
        if (v) begin
            bits = {bits[62:0], d};
            len++;
            if (first_v < 0) first_v = ticks;
            last_v = ticks;
        end
        if (dsh == 4'b1001) begin det++; detpos = len; end
        if (f) begin fd++; fdpos = len; end
    endtask

    task automatic frame(input int k, input logic [7:0] d, output int ready_at);
        cur = k;
        clr();
        set_load(k, 1'b1, d);
        tick();
        set_load(k, 1'b0, 8'h00);
        ready_at = -1;
        for (int i = 0; i < 60 && ready_at < 0; i++) begin
            tick();
            if (ready_of(k)) ready_at = ticks;
        end
    endtask

    int          r;
    int          nhs;
    int          hs_at [3];
    logic [7:0]  words [3];

    initial begin
        words = '{8'hFF, 8'h00, 8'hA5};
        reset = 1'b1;
        for (int k = 0; k < 3; k++) set_load(k, 1'b0, 8'h00);
        cur = 0;
        clr();
        repeat (2) @(negedge clk);
        chk("rst_dout",       64'(if0.dout),       64'd0);
        chk("rst_dout_valid", 64'(if0.dout_valid), 64'd0);
        chk("rst_busy",       64'(if0.busy),       64'd0);
        chk("rst_frame_done", 64'(if0.frame_done), 64'd0);
        chk("rst_load_ready", 64'(if0.load_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(if0.load_ready), 64'd1);

        // 8'hFF: no stuffing, 12 bits, ready 14 cycles after handshake
        frame(0, 8'hFF, r);
        chk("ff_len",     64'(len),   64'd12);
        chk("ff_bits",    bits,       64'b1001_11111111);
        chk("ff_fd_cnt",  64'(fd),    64'd1);
        chk("ff_fd_pos",  64'(fdpos), 64'd12);
        chk("ff_ready",   64'(r),     64'd14);
        chk("ff_first",   64'(first_v), 64'd1);
        chk("ff_nobubble", 64'(last_v - first_v + 1), 64'd12);

        // 8'hA5: one stuff bit after payload bit 5
        frame(0, 8'hA5, r);
        chk("a5_len",    64'(len),   64'd13);
        chk("a5_bits",   bits,       64'b1001_10100_0_101);
        chk("a5_fd_pos", 64'(fdpos), 64'd13);
        chk("a5_ready",  64'(r),     64'd15);

        // 8'h99: two stuffs, detector sees exactly one 1001 on preamble bit 4
        frame(0, 8'h99, r);
        chk("99_len",    64'(len),    64'd14);
        chk("99_bits",   bits,        64'b1001_100_0_1100_0_1);
        chk("99_det",    64'(det),    64'd1);
        chk("99_detpos", 64'(detpos), 64'd4);
        chk("99_fd_cnt", 64'(fd),     64'd1);

        // 8'h00 raw vs stuffed
        frame(1, 8'h00, r);
        chk("00raw_len",  64'(len), 64'd12);
        chk("00raw_bits", bits,     64'b1001_00000000);
        chk("00raw_fd",   64'(fd),  64'd1);
        frame(0, 8'h00, r);
        chk("00st_len",  64'(len), 64'd13);
        chk("00st_bits", bits,     64'b1001_00_0_000000);

        // Reset during the 3rd payload bit
        cur = 0;
        clr();
        set_load(0, 1'b1, 8'hFF);
        tick();
        set_load(0, 1'b0, 8'h00);
        repeat (6) tick();
        chk("abort_pre_dv", 64'(if0.dout_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_dout",  64'(if0.dout),       64'd0);
        chk("abort_dv",    64'(if0.dout_valid), 64'd0);
        chk("abort_busy",  64'(if0.busy),       64'd0);
        chk("abort_ready", 64'(if0.load_ready), 64'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("abort_len",  64'(len), 64'd7);
        chk("abort_bits", bits,     64'b1001_111);
        chk("abort_fd",   64'(fd),  64'd0);
        chk("abort_idle_busy", 64'(if0.busy), 64'd0);

        frame(0, 8'hFF, r);
        chk("post_len",    64'(len),   64'd12);
        chk("post_bits",   bits,       64'b1001_11111111);
        chk("post_fd_pos", 64'(fdpos), 64'd12);
        chk("post_ready",  64'(r),     64'd14);

        // load_valid together with reset: nothing latched
        reset = 1'b1;
        set_load(0, 1'b1, 8'hA5);
        repeat (2) @(negedge clk);
        chk("rstvld_busy", 64'(if0.busy), 64'd0);
        reset = 1'b0;
        set_load(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("rstvld_busy2", 64'(if0.busy),       64'd0);
        chk("rstvld_dv",    64'(if0.dout_valid), 64'd0);

        // Back-to-back, GAP_CYCLES=0, load_valid held high
        cur = 2;
        clr();
        nhs = 0;
        set_load(2, 1'b1, words[0]);
        for (int i = 0; i < 80; i++) begin
            if (nhs == 3 && if2.load_ready) break;
            if (if2.load_ready && if2.load_valid) begin
                if (nhs < 3) hs_at[nhs] = i;
                nhs++;
            end
            tick();
            if (nhs < 3) set_load(2, 1'b1, words[nhs]);
            else         set_load(2, 1'b0, 8'h00);
        end
        chk("b2b_hs_cnt", 64'(nhs),      64'd3);
        chk("b2b_hs0",    64'(hs_at[0]), 64'd0);
        chk("b2b_hs1",    64'(hs_at[1]), 64'd13);
        chk("b2b_hs2",    64'(hs_at[2]), 64'd27);
        chk("b2b_fd_cnt", 64'(fd),       64'd3);
        chk("b2b_len",    64'(len),      64'd38);
        chk("b2b_bits",   bits,
            64'({12'b1001_11111111, 13'b1001_00_0_000000, 13'b1001_10100_0_101}));
        chk("b2b_idle",   64'(last_v - first_v + 1 - len), 64'd2);
        chk("b2b_end_ready", 64'(if2.load_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
